fir_mac_sequencer: RTL
======================

# fir_mac_sequencer

Time-multiplexed controller for an N-tap FIR filter. It accepts one input sample per valid/ready handshake and stores it in a circular delay line. It then sequences N multiply-accumulate steps through a single shared multiplier and emits one saturated output sample with a one-cycle valid pulse. It replaces the fully parallel per-sample-clock filter in systems where samples arrive as strobes on the system clock, such as those generated from an NCO tick. Coefficients are runtime-programmable.

## Interface
- N, 8, number of taps (≥2)
- X_W, 7, signed input sample width
- C_W, 8, signed coefficient width
- Y_W, 16, signed output width; accumulator width ACC_W = X_W + C_W + clog2(N)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  x_in is valid this cycle
- in_ready  out  1  block can accept a sample; equals (state == IDLE)
- x_in  in  X_W  signed input sample x[n]
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(N)  tap index k
- coef_wdata  in  C_W  signed coefficient value
- out_valid  out  1  one-cycle pulse; y_out is valid this cycle
- y_out  out  Y_W  signed output y[n]; holds its value between pulses
- busy  out  1  high in MAC and DONE states

## Operation
- Computes y[n] = sat( Σ_{k=0..N-1} c[k]·x[n−k] ), with full-precision signed products and accumulation in ACC_W bits (no internal overflow).
- Saturation: values above 2^(Y_W−1)−1 clamp to that maximum; values below −2^(Y_W−1) clamp to that minimum.
- Delay line: N × X_W registers plus write pointer wptr. The newest sample is at wptr; tap k reads delay[(wptr − k) mod N].
- FSM states: IDLE, MAC, DONE.
  - IDLE: in_ready = 1. On in_valid at a clock edge, write x_in to delay[wptr], set acc = 0, set k = 0, and go to MAC.
  - MAC: each edge performs acc += c[k]·delay[(wptr − k) mod N] and k++. On the edge with k == N−1, go to DONE.
  - DONE: on the edge, set y_out = sat(acc), set out_valid = 1 for the next cycle, set wptr = (wptr + 1) mod N, and go to IDLE.
- in_valid is ignored outside IDLE; the sample is not captured and no error is flagged. Upstream must hold x_in until in_ready.
- Coefficient writes:
  - A write is accepted only in IDLE; coef_we is ignored in MAC and DONE.
  - coef_addr ≥ N is ignored.
  - A write on the same edge as a sample accept takes effect at that edge, and that sample uses the new coefficient.
- Reset (any state, including mid-MAC) takes effect at the next edge:
  - state = IDLE, k = 0, acc = 0, wptr = 0.
  - All delay registers = 0.
  - All c[k] = 1, giving an N-sample moving sum.
  - y_out = 0, out_valid = 0.
  - An in-flight sample is discarded with no out_valid.

## Timing
- Reset values: in_ready = 1, busy = 0, out_valid = 0, y_out = 0.
- E0 is the accept edge (in_valid & in_ready). MAC updates occur at E1..EN. y_out and out_valid register at E(N+1).
- Latency: out_valid is high in the cycle after E(N+1), i.e. N+1 edges after accept.
- in_ready returns high in the same cycle out_valid is high. The earliest next accept is E(N+2), giving a sustained throughput of one sample per N+2 cycles.
- busy is high from the cycle after E0 through the cycle before out_valid.
- out_valid is exactly one cycle wide; back-to-back pulses are impossible (minimum spacing N+2 cycles).
- wptr wrap: after N samples, wptr returns to 0 and the oldest sample is overwritten. Tap indexing remains correct across the wrap.

## Test plan
- Unit step with reset coefficients (all 1, N=8): 12 samples of x=1, each accepted as soon as in_ready → y = 1,2,3,4,5,6,7,8,8,8,8,8. Each out_valid occurs exactly 9 edges after its accept.
- Impulse response: program c[k]=k+1 in IDLE, then feed x = 1,0,0,0,0,0,0,0,0,0 → y = 1,2,3,4,5,6,7,8,0,0. Covers wptr wrap-around.
- Saturation: all c = −128, feed x = −64 ten times → y = 8192, 16384, 24576, 32767, 32767, … (positive clamp). Then all c = 127 with x = −64 → negative results clamp to −32768 once the magnitude exceeds the limit.
- Handshake and ignored writes:
  - Hold in_valid high continuously → accepts occur every 10 cycles, and no sample is captured while busy.
  - coef_we pulsed mid-MAC → no effect on the current or next result.
  - coef_we coincident with accept → the new coefficient is used by that sample.
- Reset mid-operation: assert rst at E4 of a MAC sequence → no out_valid follows. Outputs and in_ready return to reset values, and the delay line and coefficients revert (next step input x=1 → y=1).
- Randomized samples and coefficients versus a software reference model over 1000 samples, with random in_valid gaps → bit-exact y_out and correct out_valid count.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed N-tap FIR: circular delay line, programmable coefficients and one
// shared multiplier stepped once per tap, producing a saturated sample per accept.
module fir_mac_sequencer #(
   parameter  int N     = 8,
   parameter  int X_W   = 7,
   parameter  int C_W   = 8,
   parameter  int Y_W   = 16,
   localparam int PTR_W = $clog2(N)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [X_W-1:0]   x_in,
   input  logic                    coef_we,
   input  logic [PTR_W-1:0]        coef_addr,
   input  logic signed [C_W-1:0]   coef_wdata,
   output logic                    out_valid,
   output logic signed [Y_W-1:0]   y_out,
   output logic                    busy
);

   localparam int P_W   = X_W + C_W;
   localparam int ACC_W = X_W + C_W + PTR_W;
   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2 ** (Y_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2 ** (Y_W - 1)));

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                   state_q;
   logic [PTR_W-1:0]         k_q;
   logic [PTR_W-1:0]         wptr_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [X_W-1:0]    delay_q [N];
   logic signed [C_W-1:0]    coef_q  [N];
   logic signed [Y_W-1:0]    y_q;
   logic signed [Y_W-1:0]    y_d;
   logic                     out_valid_q;
   logic [PTR_W-1:0]         tap_idx;
   logic signed [P_W-1:0]    prod;
   logic                     coef_addr_ok;

   // With a power-of-two tap count every address is in range.
   if (N == (1 << PTR_W)) begin : g_addr_pow2
      assign coef_addr_ok = 1'b1;
   end else begin : g_addr_npow2
      assign coef_addr_ok = (int'(coef_addr) < N);
   end

   always_comb begin
      tap_idx = (wptr_q >= k_q) ? wptr_q - k_q : wptr_q + PTR_W'(N) - k_q;
      prod    = P_W'(delay_q[tap_idx]) * P_W'(coef_q[k_q]);
      acc_d   = acc_q + ACC_W'(prod);
      if (acc_q > ACC_MAX)      y_d = {1'b0, {(Y_W - 1){1'b1}}};
      else if (acc_q < ACC_MIN) y_d = {1'b1, {(Y_W - 1){1'b0}}};
      else                      y_d = acc_q[Y_W-1:0];
   end

   // NOTE: all state here uses non-blocking assignments so every register samples
   // pre-edge values; blocking writes would let later statements see updated state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         wptr_q      <= '0;
         acc_q       <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         // NOTE: delay line and coefficients are reset explicitly because a restart
         // must yield a clean moving-sum filter, which forces them into flops, not RAM.
         for (int i = 0; i < N; i++) begin
            delay_q[i] <= '0;
            coef_q[i]  <= C_W'(1);
         end
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (coef_we && coef_addr_ok) coef_q[coef_addr] <= coef_wdata;
               if (in_valid) begin
                  delay_q[wptr_q] <= x_in;
                  acc_q           <= '0;
                  k_q             <= '0;
                  state_q         <= MAC;
               end
            end
            MAC: begin
               acc_q <= acc_d;
               k_q   <= k_q + 1'b1;
               if (k_q == PTR_W'(N - 1)) state_q <= DONE;
            end
            DONE: begin
               y_q         <= y_d;
               out_valid_q <= 1'b1;
               wptr_q      <= (wptr_q == PTR_W'(N - 1)) ? '0 : wptr_q + 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign y_out     = y_q;

endmodule
